// File: rtl/iqmod_pkg.sv
// Shared definitions for the I/Q sample source.
//   mode_e      : source select encodings (value 3 behaves as hold)
//   UNDERRUN_W  : width of the saturating underrun counter
//   iq_mid()    : mid-scale code 2^(w-1)-1 for a w-bit sample
//   iq_full()   : full-scale code 2^w-1 for a w-bit sample
package iqmod_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_TONE   = 2'd1,
    MODE_STREAM = 2'd2,
    MODE_HOLD2  = 2'd3
  } mode_e;

  localparam int UNDERRUN_W = 16;

  function automatic int iq_mid(input int iq_w);
    return (1 << (iq_w - 1)) - 1;
  endfunction

  function automatic int iq_full(input int iq_w);
    return (1 << iq_w) - 1;
  endfunction

endpackage

// File: rtl/iq_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed {I,Q} pairs.
//   clk, areset_ : clock, asynchronous active-low reset (pointers/level only)
//   push_i/data_i: write strobe and pair; ignored while full
//   pop_i        : drop the head entry; ignored while empty
//   data_o       : current head entry (valid whenever empty_o is low)
//   full_o/empty_o/level_o : occupancy flags and count of stored entries
module iq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     areset_,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or negedge areset_) begin
    if (!areset_) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; the pointers define which entries are meaningful.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (do_push && (wr_q == AW'(gi))) begin
        mem[gi] <= data_i;
      end
    end
  end

  // Head is read combinationally so a tick can pop it straight into the outputs.
  assign data_o  = mem[rd_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/iq_sample_source.sv
// I/Q sample source for the iqmod modulator core.
//   clk, areset_      : clock, asynchronous active-low reset
//   mode              : 0/3 hold, 1 square-wave AM tone, 2 byte stream
//   byte_in/valid/ready: stream byte handshake from the USB reader
//   i_out, q_out      : registered sample pair, updated on each sample tick
//   sample_stb        : one-cycle pulse on the cycle the outputs change
//   fifo_level        : pairs currently buffered
//   underruns         : saturating count of stream ticks that found no data
//   status            : front-panel lights
module iq_sample_source
  import iqmod_pkg::*;
#(
  parameter int IQ_W       = 4,
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    areset_,
  input  logic [1:0]              mode,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic [IQ_W-1:0]         i_out,
  output logic [IQ_W-1:0]         q_out,
  output logic                    sample_stb,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [UNDERRUN_W-1:0]   underruns,
  output logic [7:0]              status
);

  localparam int PAIR_W = 2 * IQ_W;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int CNT_W  = $clog2(SAMPLE_DIV);

  localparam logic [IQ_W-1:0] MID     = IQ_W'(iq_mid(IQ_W));
  localparam logic [IQ_W-1:0] FULL    = IQ_W'(iq_full(IQ_W));
  localparam logic [IQ_W-1:0] TONE_HI = IQ_W'(2 * iq_mid(IQ_W));

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  // ---------------------------------------------------------------------
  // Sample tick
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick  = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  // ---------------------------------------------------------------------
  // Byte assembler
  // ---------------------------------------------------------------------
  logic              accept;
  logic              push;
  logic [PAIR_W-1:0] push_data;
  logic              fifo_full, fifo_empty;
  logic [PAIR_W-1:0] head;

  assign byte_ready = (mode_s == MODE_STREAM) & ~fifo_full;
  assign accept     = byte_valid & byte_ready;

  if (IQ_W == 8) begin : g_asm8
    logic       phase_q, phase_d;
    logic [7:0] first_q, first_d;

    // Leaving stream mode drops any half-received pair.
    always_comb begin
      phase_d = phase_q;
      first_d = first_q;
      if (mode_s != MODE_STREAM) begin
        phase_d = 1'b0;
      end else if (accept) begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          first_d = byte_in;
        end
      end
    end

    always_ff @(posedge clk or negedge areset_) begin
      if (!areset_) begin
        phase_q <= 1'b0;
        first_q <= '0;
      end else begin
        phase_q <= phase_d;
        first_q <= first_d;
      end
    end

    assign push      = accept & phase_q;
    assign push_data = {first_q, byte_in};
  end else begin : g_asm4
    // One byte carries a whole pair: I in the high nibble, Q in the low.
    assign push      = accept;
    assign push_data = byte_in;
  end

  // ---------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------
  logic pop;
  assign pop = tick & (mode_s == MODE_STREAM) & ~fifo_empty;

  iq_fifo #(
    .W     (PAIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .areset_ (areset_),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Status lights show the occupancy as it will be after this cycle's
  // push/pop, so the panel matches fifo_level on the following cycle.
  logic [LVL_W-1:0] lvl_next;
  logic [3:0]       lvl4;

  assign lvl_next = fifo_level + LVL_W'(push) - LVL_W'(pop);

  if (LVL_W >= 4) begin : g_lvl_trunc
    assign lvl4 = lvl_next[3:0];
  end else begin : g_lvl_ext
    assign lvl4 = {{(4 - LVL_W){1'b0}}, lvl_next};
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  logic [IQ_W-1:0]       i_q, i_d;
  logic [IQ_W-1:0]       q_q, q_d;
  logic [7:0]            status_q, status_d;
  logic                  stb_q, stb_d;
  logic [UNDERRUN_W-1:0] und_q, und_d;

  always_comb begin
    i_d      = i_q;
    q_d      = q_q;
    status_d = status_q;
    und_d    = und_q;
    stb_d    = tick;
    if (tick) begin
      case (mode_s)
        MODE_TONE: begin
          status_d = ~status_q;
          i_d      = status_d[0] ? TONE_HI : MID;
          q_d      = MID;
        end
        MODE_STREAM: begin
          if (!fifo_empty) begin
            {i_d, q_d} = head;
          end else if (und_q != '1) begin
            und_d = und_q + UNDERRUN_W'(1);
          end
          status_d = {(lvl_next == '0), (lvl_next == LVL_W'(DEPTH)),
                      (und_d != '0), 1'b0, lvl4};
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge areset_) begin
    if (!areset_) begin
      cnt_q    <= '0;
      i_q      <= FULL;
      q_q      <= MID;
      status_q <= 8'hff;
      stb_q    <= 1'b0;
      und_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      i_q      <= i_d;
      q_q      <= q_d;
      status_q <= status_d;
      stb_q    <= stb_d;
      und_q    <= und_d;
    end
  end

  assign i_out      = i_q;
  assign q_out      = q_q;
  assign status     = status_q;
  assign sample_stb = stb_q;
  assign underruns  = und_q;

endmodule

// File: tb/tb_iq_sample_source.sv
// Bench for iq_sample_source: two instances (4-bit and 8-bit samples)
// checked every cycle against a behavioural model, plus a table of
// directed tone/stream vectors and hand-written multi-cycle sequences.
module tb_iq_sample_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset_;
  logic [1:0]  mode4, mode8;
  logic [7:0]  b4, b8;
  logic        bv4, bv8;
  logic        rdy4, rdy8, stb4, stb8;
  logic [3:0]  i4, q4;
  logic [7:0]  i8, q8;
  logic [2:0]  lvl4, lvl8;
  logic [15:0] und4, und8;
  logic [7:0]  st4, st8;

  iq_sample_source #(.IQ_W(4), .DEPTH(4), .SAMPLE_DIV(8)) dut4 (
    .clk(clk), .areset_(areset_), .mode(mode4), .byte_in(b4),
    .byte_valid(bv4), .byte_ready(rdy4), .i_out(i4), .q_out(q4),
    .sample_stb(stb4), .fifo_level(lvl4), .underruns(und4), .status(st4)
  );

  iq_sample_source #(.IQ_W(8), .DEPTH(4), .SAMPLE_DIV(32)) dut8 (
    .clk(clk), .areset_(areset_), .mode(mode8), .byte_in(b8),
    .byte_valid(bv8), .byte_ready(rdy8), .i_out(i8), .q_out(q8),
    .sample_stb(stb8), .fifo_level(lvl8), .underruns(und8), .status(st8)
  );

  int n_vec;
  int n_bad;

  // -------------------------------------------------------------------
  // Behavioural model: FIFO as a shift-down list of pairs, tick derived
  // from a cycle index modulo the divider.
  // -------------------------------------------------------------------
  int m_cnt[2], m_i[2], m_q[2], m_stat[2], m_stb[2], m_und[2];
  int m_lvl[2], m_phase[2], m_first[2];
  int m_fi[2][4];
  int m_fq[2][4];

  function automatic int mid_of(input int k);  return (k == 0) ? 7 : 127;  endfunction
  function automatic int full_of(input int k); return (k == 0) ? 15 : 255; endfunction
  function automatic int div_of(input int k);  return (k == 0) ? 8 : 32;   endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_i[k] = full_of(k); m_q[k] = mid_of(k);
      m_stat[k] = 255; m_stb[k] = 0; m_und[k] = 0; m_lvl[k] = 0;
      m_phase[k] = 0; m_first[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input int md, input int bv, input int bb);
    int tick, acc, have, pi, pq;
    tick = (m_cnt[k] == div_of(k) - 1);
    m_cnt[k] = (m_cnt[k] + 1) % div_of(k);
    acc  = (bv != 0) && (md == 2) && (m_lvl[k] < 4);
    have = 0; pi = 0; pq = 0;
    if (acc != 0) begin
      if (k == 0) begin
        pi = bb / 16; pq = bb % 16; have = 1;
      end else if (m_phase[k] == 0) begin
        m_first[k] = bb; m_phase[k] = 1;
      end else begin
        pi = m_first[k]; pq = bb; have = 1; m_phase[k] = 0;
      end
    end
    if (md != 2) m_phase[k] = 0;
    m_stb[k] = tick;
    if (tick != 0) begin
      if (md == 1) begin
        m_stat[k] = 255 - m_stat[k];
        m_i[k] = mid_of(k) + (((m_stat[k] % 2) == 1) ? mid_of(k) : 0);
        m_q[k] = mid_of(k);
      end else if (md == 2) begin
        if (m_lvl[k] > 0) begin
          m_i[k] = m_fi[k][0]; m_q[k] = m_fq[k][0];
          for (int j = 0; j < 3; j++) begin
            m_fi[k][j] = m_fi[k][j+1]; m_fq[k][j] = m_fq[k][j+1];
          end
          m_lvl[k]--;
        end else if (m_und[k] < 65535) begin
          m_und[k]++;
        end
      end
    end
    if (have != 0) begin
      m_fi[k][m_lvl[k]] = pi; m_fq[k][m_lvl[k]] = pq; m_lvl[k]++;
    end
    if (tick != 0 && md == 2)
      m_stat[k] = ((m_lvl[k] == 0) ? 128 : 0) + ((m_lvl[k] == 4) ? 64 : 0) +
                  ((m_und[k] != 0) ? 32 : 0) + m_lvl[k];
  endtask

  always @(posedge clk or negedge areset_) begin
    if (!areset_) begin
      model_reset();
    end else begin
      model_edge(0, int'(mode4), int'(bv4), int'(b4));
      model_edge(1, int'(mode8), int'(bv8), int'(b8));
    end
  end

  // -------------------------------------------------------------------
  // Checking helpers
  // -------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("i4", int'(i4), m_i[0]);         chk("q4", int'(q4), m_q[0]);
    chk("stb4", int'(stb4), m_stb[0]);   chk("lvl4", int'(lvl4), m_lvl[0]);
    chk("und4", int'(und4), m_und[0]);   chk("status4", int'(st4), m_stat[0]);
    chk("ready4", int'(rdy4), (mode4 == 2'd2 && m_lvl[0] < 4) ? 1 : 0);
    chk("i8", int'(i8), m_i[1]);         chk("q8", int'(q8), m_q[1]);
    chk("stb8", int'(stb8), m_stb[1]);   chk("lvl8", int'(lvl8), m_lvl[1]);
    chk("und8", int'(und8), m_und[1]);   chk("status8", int'(st8), m_stat[1]);
    chk("ready8", int'(rdy8), (mode8 == 2'd2 && m_lvl[1] < 4) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wait_stb(input int k);
    int n;
    n = 0;
    while (((k == 0) ? stb4 : stb8) !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    if (n >= 80) chk("stb_timeout", 0, 1);
  endtask

  typedef struct {
    int mode; int valid; int b;
    int ei; int eq; int eund; int estat;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[6];
    int first, acc, blk_at, blk_lvl, got, guard, r;
    logic [7:0] bytes[10];
    int gi_[5];
    int gq_[5];

    tv[0] = '{1, 0, 0,    7,  7, 0, 8'h00};
    tv[1] = '{1, 0, 0,   14,  7, 0, 8'hff};
    tv[2] = '{1, 0, 0,    7,  7, 0, 8'h00};
    tv[3] = '{2, 1, 8'hA5, 10, 5, 0, 8'h80};
    tv[4] = '{2, 1, 8'h3C,  3, 12, 0, 8'h80};
    tv[5] = '{2, 0, 0,    3, 12, 1, 8'hA0};

    n_vec = 0; n_bad = 0;
    areset_ = 1'b0;
    mode4 = 2'd0; mode8 = 2'd0; b4 = 8'h00; b8 = 8'h00; bv4 = 1'b0; bv8 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_i", int'(i4), 15);       chk("rst_q", int'(q4), 7);
    chk("rst_status", int'(st4), 255); chk("rst_ready", int'(rdy4), 0);
    chk("rst_stb", int'(stb4), 0);    chk("rst_lvl", int'(lvl4), 0);
    chk("rst_i8", int'(i8), 255);     chk("rst_q8", int'(q8), 127);

    // First strobe arrives on the 8th edge after release
    areset_ = 1'b1;
    first = 0;
    for (int n = 1; n <= 20 && first == 0; n++) begin
      step();
      if (stb4) first = n;
    end
    chk("first_stb_cycle", first, 8);

    // Table: one entry per sample tick on the 4-bit instance
    for (int v = 0; v < 6; v++) begin
      mode4 = 2'(tv[v].mode); bv4 = (tv[v].valid != 0); b4 = 8'(tv[v].b);
      step();
      bv4 = 1'b0;
      wait_stb(0);
      chk("vec_i", int'(i4), tv[v].ei);
      chk("vec_q", int'(q4), tv[v].eq);
      chk("vec_und", int'(und4), tv[v].eund);
      chk("vec_status", int'(st4), tv[v].estat);
      $display("vec %0d: mode=%0d i=%0d q=%0d und=%0d status=%02h",
               v, tv[v].mode, i4, q4, und4, st4);
    end

    // Push coincident with the tick pop at level 2
    b4 = 8'h12; bv4 = 1'b1; step();
    b4 = 8'h34; step();
    bv4 = 1'b0;
    repeat (5) step();
    chk("coinc_lvl_before", int'(lvl4), 2);
    b4 = 8'h56; bv4 = 1'b1; step();
    bv4 = 1'b0;
    chk("coinc_stb", int'(stb4), 1);
    chk("coinc_i", int'(i4), 1); chk("coinc_q", int'(q4), 2);
    chk("coinc_lvl", int'(lvl4), 2);
    step(); wait_stb(0);
    chk("coinc_i2", int'(i4), 3); chk("coinc_q2", int'(q4), 4);
    step(); wait_stb(0);
    chk("coinc_i3", int'(i4), 5); chk("coinc_q3", int'(q4), 6);
    chk("coinc_lvl_end", int'(lvl4), 0);
    $display("coincident push/pop: pairs (1,2) (3,4) (5,6) sequence done");

    // 10 back-to-back bytes into the 8-bit instance (DEPTH=4)
    for (int n = 0; n < 10; n++) bytes[n] = 8'(8'h21 + 17 * n);
    step(); wait_stb(1);
    mode8 = 2'd2;
    acc = 0; blk_at = -1; blk_lvl = -1; got = 0; guard = 0;
    for (int c = 0; c < 60 && acc < 10; c++) begin
      bv8 = 1'b1; b8 = bytes[acc];
      #1;
      r = int'(rdy8);
      if (r == 0 && blk_at < 0) begin
        blk_at = acc; blk_lvl = int'(lvl8);
      end
      step();
      if (r != 0) acc++;
      if (stb8 && got < 5) begin gi_[got] = int'(i8); gq_[got] = int'(q8); got++; end
    end
    bv8 = 1'b0;
    chk("block_after_bytes", blk_at, 8);
    chk("level_at_block", blk_lvl, 4);
    chk("all_bytes_accepted", acc, 10);
    while (got < 5 && guard < 300) begin
      step();
      if (stb8) begin gi_[got] = int'(i8); gq_[got] = int'(q8); got++; end
      guard++;
    end
    chk("pairs_out", got, 5);
    for (int p = 0; p < got; p++) begin
      chk("pair_i", gi_[p], int'(bytes[2*p]));
      chk("pair_q", gq_[p], int'(bytes[2*p+1]));
      $display("pair %0d: i=%02h q=%02h", p, gi_[p], gq_[p]);
    end

    // Stale half-pair dropped when leaving stream mode
    b8 = 8'h11; bv8 = 1'b1; step();
    bv8 = 1'b0; mode8 = 2'd0; step();
    mode8 = 2'd2; b8 = 8'h22; bv8 = 1'b1; step();
    b8 = 8'h33; step();
    bv8 = 1'b0;
    chk("stale_lvl", int'(lvl8), 1);
    step(); wait_stb(1);
    chk("stale_i", int'(i8), 8'h22); chk("stale_q", int'(q8), 8'h33);
    $display("stale byte test: i=%02h q=%02h", i8, q8);

    // Asynchronous reset mid-pair and mid-count
    b8 = 8'h77; bv8 = 1'b1; step();
    bv8 = 1'b0; step();
    #2 areset_ = 1'b0;
    #1;
    check_all();
    chk("arst_i8", int'(i8), 255); chk("arst_lvl8", int'(lvl8), 0);
    chk("arst_st4", int'(st4), 255); chk("arst_und4", int'(und4), 0);
    areset_ = 1'b1;
    $display("async reset applied mid-pair");

    // Randomised traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        r = int'($urandom_range(0, 5));
        mode4 = (r >= 3) ? 2'd2 : 2'(r);
      end
      if ($urandom_range(0, 31) == 0) begin
        r = int'($urandom_range(0, 5));
        mode8 = (r >= 3) ? 2'd2 : 2'(r);
      end
      bv4 = ($urandom_range(0, 6) == 0);
      bv8 = ($urandom_range(0, 14) == 0);
      b4 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      step();
    end
    $display("random phase: 3000 cycles");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/iq_sample_source.md
# iq_sample_source

Parametrised I/Q sample source feeding the `iqmod` modulator core. It supersedes the fixed 4-bit I/Q registers and hard-wired 1 kHz AM tone in the `modulator` top. Samples come from one of three selectable sources: hold, internal square-wave AM tone, or a byte stream from the `ft245r_fifo` reader. Stream bytes are unpacked into I/Q words, buffered in a FIFO, and released at a fixed sample rate with underrun accounting.

## Interface
- `IQ_W`, 4: I and Q width in bits; legal values 4 or 8.
- `DEPTH`, 16: sample FIFO depth in I/Q pairs; power of two, ≥2.
- `SAMPLE_DIV`, 50000: `clk` cycles per sample tick; ≥2.
- `clk`  in  1  system clock (single clock domain).
- `areset_`  in  1  asynchronous, active-low reset.
- `mode`  in  2  source select: 0 = hold, 1 = tone, 2 = stream, 3 = hold.
- `byte_in`  in  8  stream byte from the USB reader.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  byte is accepted when `byte_valid & byte_ready`.
- `i_out`  out  IQ_W  I sample to `iqmod`.
- `q_out`  out  IQ_W  Q sample to `iqmod`.
- `sample_stb`  out  1  one-cycle pulse on the cycle `i_out`/`q_out` change.
- `fifo_level`  out  $clog2(DEPTH)+1  pairs currently buffered.
- `underruns`  out  16  saturating count of stream ticks that found the FIFO empty.
- `status`  out  8  front-panel lights.

## Operation
- Constants: MID = 2^(IQ_W-1)-1, FULL = 2^IQ_W-1.
- Reset values:
  - `i_out`=FULL, `q_out`=MID.
  - `status`=8'hff.
  - FIFO empty, `fifo_level`=0, `underruns`=0.
  - Tick counter 0, assembler empty.
  - `sample_stb`=0, `byte_ready`=0.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 in every mode and wraps.
  - An internal `tick` is asserted when count == SAMPLE_DIV-1.
- Byte assembler (stream mode only):
  - IQ_W=4: each byte is one pair; I=byte[7:4], Q=byte[3:0].
  - IQ_W=8: the first byte is I, the second is Q. A one-bit phase flag tracks which byte is expected.
  - A completed pair is pushed into the FIFO in the same cycle the last byte is accepted.
  - When `mode` != 2, the phase flag clears, so a half-received pair is discarded.
- `byte_ready` = (mode==2) & (fifo_level < DEPTH). Registered-output FIFO pointers are not required; combinational from level is acceptable.
- On `tick`, by mode:
  - Hold: no output change. `sample_stb` still pulses.
  - Tone:
    - `status` <= ~`status`.
    - `i_out` <= MID + (new status bit0 ? MID : 0).
    - `q_out` <= MID.
    - Square-wave AM at clk/(2·SAMPLE_DIV).
  - Stream:
    - FIFO non-empty: pop the head into `i_out`/`q_out`.
    - FIFO empty: hold the last values and increment `underruns`, saturating at 16'hffff.
    - `status` = {fifo_empty, fifo_full, underruns!=0, 1'b0, fifo_level[3:0] zero-extended or truncated}.
- Simultaneous push and pop on the tick cycle: both take effect, and `fifo_level` is unchanged.
- Mode changes take effect at the next tick. FIFO contents are retained across mode changes.

## Timing
- `i_out`, `q_out`, `status` and `sample_stb` are registered, updating on the clock edge at the end of the `tick` cycle. `sample_stb` is high for exactly that one following cycle.
- Accepted byte to FIFO occupancy: 1 cycle. Pair to `i_out` appears at the first tick at least 1 cycle after the push.
- `areset_` assertion clears all state immediately, mid-pair or mid-count. Deassertion is synchronised externally.

## Structure
- Shared package `iqmod_pkg`:
  - mode encodings MODE_HOLD, MODE_TONE, MODE_STREAM;
  - the MID/FULL functions of IQ_W;
  - the underrun counter width.
- One sub-module, `iq_fifo`: a synchronous FIFO of width 2·IQ_W and depth DEPTH, with push, pop, full, empty and level.
- Top-level instantiation replaces the `i`/`q` registers and tone counter in `modulator`.

## Test plan
- Reset with IQ_W=4, SAMPLE_DIV=8 → `i_out`=15, `q_out`=7, `status`=8'hff, `byte_ready`=0; first `sample_stb` on cycle 8 after reset release.
- Tone mode, IQ_W=4, SAMPLE_DIV=8 → `i_out` alternates 7, 14, 7… every 8 cycles; `q_out`=7; `status` toggles between 00 and ff.
- Stream mode, IQ_W=4: send bytes 8'hA5 and 8'h3C → successive ticks give (I,Q)=(10,5) then (3,12); the next tick holds (3,12) and `underruns`=1.
- Stream mode, IQ_W=8, DEPTH=4: send 10 bytes back-to-back with no ticks → `byte_ready` drops after 8 bytes; `fifo_level`=4; the remaining bytes wait, and none are lost.
- IQ_W=8: send a single byte 8'h11, switch to hold, then back to stream and send 8'h22, 8'h33 → the output pair is (0x22,0x33); the stale byte is discarded.
- Push coincident with the tick pop at level 2 → level stays 2, and the popped pair is the oldest one.
